pcs_block_lock: RTL
===================

PCS_BLOCK_LOCK -- requirements
Module: pcs_block_lock

Interface
REQ-001 SHALL have parameter SH_GOOD_N, default 64: consecutive-window length in blocks used to declare and re-check lock.
REQ-002 SHALL have parameter SH_BAD_N, default 16: invalid sync headers within one SH_GOOD_N window that cause loss of lock.
REQ-003 SHALL have parameter SLIP_WAIT_N, default 2: valid blocks ignored after a slip while the gearbox realigns.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is in this domain.
REQ-005 SHALL have port nreset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port rx_locked_i, input, 1: SerDes CDR lock (signal_ok); low forces loss of lock.
REQ-007 SHALL have port valid_i, input, 1: a new 66-bit block's sync header is present on sh_i this cycle.
REQ-008 SHALL have port sh_i, input, 2: sync header of the current block.
REQ-009 SHALL have port slip_o, output, 1: one-cycle pulse requesting a 1-bit slip from the rx gearbox.
REQ-010 SHALL have port block_lock_o, output, 1: block alignment achieved.

Function
REQ-011 SHALL treat sh_i as valid iff sh_i is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid; sh_i is sampled only when valid_i=1.
REQ-012 SHALL implement states INIT, TEST, SLIP_WAIT; sh_cnt is 7 bits (0..SH_GOOD_N); bad_cnt is 5 bits (0..SH_BAD_N).
REQ-013 INIT: block_lock_o=0 and counters 0; go to TEST on the first cycle rx_locked_i=1.
REQ-014 TEST, unlocked, valid_i with valid sh: sh_cnt+1; when the increment reaches SH_GOOD_N, set block_lock_o=1 next cycle and clear both counters.
REQ-015 TEST, unlocked, valid_i with invalid sh: assert slip_o for exactly that next cycle, clear counters, go to SLIP_WAIT.
REQ-016 TEST, locked, valid_i: sh_cnt+1; bad_cnt+1 on invalid sh.
REQ-017 TEST, locked: when bad_cnt reaches SH_BAD_N, deassert block_lock_o, pulse slip_o, clear counters and go to SLIP_WAIT in the same update.
REQ-018 TEST, locked: when sh_cnt reaches SH_GOOD_N with bad_cnt<SH_BAD_N, clear both counters and keep block_lock_o=1.
REQ-019 Simultaneous case: when sh_cnt reaches SH_GOOD_N on the same block that makes bad_cnt reach SH_BAD_N, the loss of lock (REQ-017) SHALL win.
REQ-020 SLIP_WAIT: SHALL count SLIP_WAIT_N valid_i cycles and ignore sh_i, then return to TEST with counters 0; slip_o SHALL NOT re-assert during SLIP_WAIT.
REQ-021 Cycles with valid_i=0 SHALL not change counters or state, except for the rx_locked_i rule in REQ-022.
REQ-022 rx_locked_i=0 in any state SHALL move the block to INIT on the next edge, with block_lock_o=0, slip_o=0 and counters cleared.
REQ-023 Latency: slip_o and block_lock_o are registered, one cycle after the deciding valid_i edge.

Reset
REQ-024 On nreset=0, the block SHALL immediately enter state INIT with slip_o=0, block_lock_o=0, sh_cnt=0, bad_cnt=0 and the slip-wait counter 0, regardless of clk.
REQ-025 Reset deassertion SHALL take effect at the next clk edge; reset asserted mid-window SHALL discard all partial counts.

Structure
REQ-026 Shared package pcs_pkg SHALL hold the sync-header constants SYNC_HEAD_DATA=2'b01 and SYNC_HEAD_CTRL=2'b10, plus the lock-FSM state enum.
REQ-027 The block SHALL be a single module with no sub-module; it sits between the rx gearbox slip input and the descrambler enable inside the 10G PCS rx path.

Verification
REQ-028 rx_locked_i=1, 64 valid blocks with sh=01 -> block_lock_o=1 exactly one cycle after the 64th block; slip_o never asserts.
REQ-029 Unlocked, 10 good blocks then sh=11 -> one slip_o pulse; the next 2 valid blocks are ignored; lock requires 64 further good blocks.
REQ-030 Locked, 15 invalid blocks among 64 -> block_lock_o stays 1 and counters restart; 16 invalid blocks within 64 -> block_lock_o=0 plus one slip_o pulse.
REQ-031 Locked, 16th invalid header arriving as the 64th block of the window -> lock lost, slip_o pulses (REQ-019).
REQ-032 Locked, rx_locked_i dropped for 1 cycle -> block_lock_o=0 next cycle, no slip; re-lock after 64 good blocks.
REQ-033 nreset asserted after 40 good blocks -> outputs 0 immediately; after release, 64 fresh good blocks are needed to lock; valid_i gaps of 3 idle cycles are inserted throughout without changing results.

Source files
------------

// File: rtl/pcs_pkg.sv
// rtl/pcs_pkg.sv - shared 10G PCS rx constants and block-lock state type
//
// Purpose : sync-header encodings, the block-lock FSM state enum and a
//           header validity helper shared across the rx PCS.
// Ports   : none (package).

package pcs_pkg;

    localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
    localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_TEST      = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } lock_state_t;

    // 00 and 11 are never legal 64b/66b sync headers.
    function automatic logic sh_valid(input logic [1:0] sh);
        return (sh == SYNC_HEAD_DATA) || (sh == SYNC_HEAD_CTRL);
    endfunction

endpackage

// File: rtl/pcs_block_lock.sv
// rtl/pcs_block_lock.sv - 64b/66b block alignment (block lock) state machine
//
// Purpose : hunts for 66-bit block alignment by checking sync headers,
//           requesting single-bit gearbox slips on bad headers, and
//           monitors the locked stream for excessive header errors.
// Ports   : clk           - single clock
//           nreset        - asynchronous active-low reset
//           rx_locked_i   - SerDes CDR lock; low forces loss of lock
//           valid_i       - a new block's sync header is on sh_i
//           sh_i[1:0]     - sync header of the current block
//           slip_o        - one-cycle 1-bit slip request to the rx gearbox
//           block_lock_o  - block alignment achieved

module pcs_block_lock
    import pcs_pkg::*;
#(
    parameter int SH_GOOD_N   = 64,
    parameter int SH_BAD_N    = 16,
    parameter int SLIP_WAIT_N = 2
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx_locked_i,
    input  logic       valid_i,
    input  logic [1:0] sh_i,
    output logic       slip_o,
    output logic       block_lock_o
);

    localparam int WAIT_W = $clog2(SLIP_WAIT_N + 1);

    lock_state_t       state;
    logic [6:0]        sh_cnt;
    logic [4:0]        bad_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic              sh_ok;
    logic [6:0]        sh_cnt_inc;
    logic [4:0]        bad_cnt_nxt;
    logic [WAIT_W-1:0] wait_cnt_inc;

    assign sh_ok        = sh_valid(sh_i);
    assign sh_cnt_inc   = sh_cnt + 7'd1;
    assign bad_cnt_nxt  = bad_cnt + {4'd0, ~sh_ok};
    assign wait_cnt_inc = wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= ST_INIT;
            sh_cnt       <= '0;
            bad_cnt      <= '0;
            wait_cnt     <= '0;
            slip_o       <= 1'b0;
            block_lock_o <= 1'b0;
        end else begin
            // slip_o is a strobe: only the deciding branch raises it.
            slip_o <= 1'b0;
            if (!rx_locked_i) begin
                state        <= ST_INIT;
                sh_cnt       <= '0;
                bad_cnt      <= '0;
                wait_cnt     <= '0;
                block_lock_o <= 1'b0;
            end else begin
                case (state)
                    ST_INIT: begin
                        // The CDR-lock cycle itself only arms the hunt.
                        state        <= ST_TEST;
                        sh_cnt       <= '0;
                        bad_cnt      <= '0;
                        wait_cnt     <= '0;
                        block_lock_o <= 1'b0;
                    end
                    ST_TEST: begin
                        if (valid_i) begin
                            if (!block_lock_o) begin
                                if (sh_ok) begin
                                    if (sh_cnt_inc == 7'(SH_GOOD_N)) begin
                                        block_lock_o <= 1'b1;
                                        sh_cnt       <= '0;
                                        bad_cnt      <= '0;
                                    end else begin
                                        sh_cnt <= sh_cnt_inc;
                                    end
                                end else begin
                                    slip_o   <= 1'b1;
                                    sh_cnt   <= '0;
                                    bad_cnt  <= '0;
                                    wait_cnt <= '0;
                                    state    <= ST_SLIP_WAIT;
                                end
                            end else begin
                                // Error threshold is tested first so it wins
                                // over a window closing on the same block.
                                if (bad_cnt_nxt == 5'(SH_BAD_N)) begin
                                    block_lock_o <= 1'b0;
                                    slip_o       <= 1'b1;
                                    sh_cnt       <= '0;
                                    bad_cnt      <= '0;
                                    wait_cnt     <= '0;
                                    state        <= ST_SLIP_WAIT;
                                end else if (sh_cnt_inc == 7'(SH_GOOD_N)) begin
                                    sh_cnt  <= '0;
                                    bad_cnt <= '0;
                                end else begin
                                    sh_cnt  <= sh_cnt_inc;
                                    bad_cnt <= bad_cnt_nxt;
                                end
                            end
                        end
                    end
                    ST_SLIP_WAIT: begin
                        // Headers here straddle the old and new alignment.
                        if (valid_i) begin
                            if (wait_cnt_inc == WAIT_W'(SLIP_WAIT_N)) begin
                                wait_cnt <= '0;
                                sh_cnt   <= '0;
                                bad_cnt  <= '0;
                                state    <= ST_TEST;
                            end else begin
                                wait_cnt <= wait_cnt_inc;
                            end
                        end
                    end
                    default: begin
                        state        <= ST_INIT;
                        block_lock_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
